// File: rtl/inst_sram_axi_rd_bridge_pkg.sv
// ============================================================================
// Package  : inst_sram_axi_rd_bridge_pkg
// Desc     : AXI3 read-channel constants and word helpers for the fetch bridge
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_sram_axi_rd_bridge_pkg;

    localparam logic [7:0] AXI_LEN_SINGLE  = 8'd0;
    localparam logic [2:0] AXI_SIZE_WORD   = 3'd2;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
    localparam logic [3:0] AXI_CACHE_NONE  = 4'd0;
    localparam logic [2:0] AXI_PROT_NONE   = 3'd0;

    typedef logic [31:0] word_t;

    function automatic word_t word_align(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_sram_axi_rd_bridge_if.sv
// ============================================================================
// Interface : inst_sram_axi_rd_bridge_if
// Desc      : Fetch-side SRAM-like request/response plus AXI3 AR/R channels
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface inst_sram_axi_rd_bridge_if;

    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    // Bridge view: responder to fetch, initiator on AXI.
    modport slave (
        input  inst_sram_req, inst_sram_addr,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    // Environment view: fetch stage plus crossbar.
    modport master (
        output inst_sram_req, inst_sram_addr,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

`default_nettype wire

// File: rtl/inst_sram_axi_rd_bridge_axi_ar_slot.sv
// ============================================================================
// Module   : inst_sram_axi_rd_bridge_axi_ar_slot
// Desc     : One-entry AXI read-address holding register with valid/ready
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_sram_axi_rd_bridge_axi_ar_slot
    import inst_sram_axi_rd_bridge_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  load,
    input  word_t load_addr,
    input  logic  arready,
    output logic  arvalid,
    output word_t araddr
);

    logic  r_arvalid;
    word_t r_araddr;

    // load is only raised while the slot is empty, so it never races the handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
        end else if (load) begin
            r_arvalid <= 1'b1;
            r_araddr  <= word_align(load_addr);
        end else if (r_arvalid && arready) begin
            r_arvalid <= 1'b0;
        end
    end

    assign arvalid = r_arvalid;
    assign araddr  = r_araddr;

endmodule

`default_nettype wire

// File: rtl/inst_sram_axi_rd_bridge.sv
// ============================================================================
// Module   : inst_sram_axi_rd_bridge
// Desc     : Instruction-fetch SRAM-like to AXI3 single-beat read bridge
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_sram_axi_rd_bridge
    import inst_sram_axi_rd_bridge_pkg::*;
#(
    parameter int         MAX_OUTSTANDING = 2,
    parameter logic [3:0] AXI_ID          = 4'd0
)
(
    input  logic                       clk,
    input  logic                       reset,
    inst_sram_axi_rd_bridge_if.slave   bus
);

    localparam logic [1:0] C_MAX_OUT = 2'(MAX_OUTSTANDING);

    logic [1:0] r_cnt;
    logic [1:0] r_inflight;
    logic [2:0] r_discard;
    logic       r_data_ok;
    word_t      r_rdata;

    logic       w_arvalid;
    word_t      w_araddr;
    logic       w_accept;
    logic       w_ar_hs;
    logic       w_r_hs;
    logic       w_r_fwd;
    logic       w_inflight_dec;
    logic [1:0] w_pending;
    logic       w_unused_r;

    assign w_accept = bus.inst_sram_req & ~w_arvalid & (r_cnt < C_MAX_OUT) & ~reset;
    assign w_ar_hs  = w_arvalid & bus.arready;
    assign w_r_hs   = bus.rvalid & bus.rready;

    // A beat already captured this cycle still sits in r_cnt until its data_ok retires it.
    assign w_pending      = {1'b0, r_data_ok};
    assign w_r_fwd        = w_r_hs & (r_discard == 3'd0) & (r_cnt > w_pending);
    assign w_inflight_dec = w_r_hs & (r_discard == 3'd0) & (r_inflight != 2'd0);

    inst_sram_axi_rd_bridge_axi_ar_slot u_ar_slot (
        .clk       (clk),
        .reset     (reset),
        .load      (w_accept),
        .load_addr (bus.inst_sram_addr),
        .arready   (bus.arready),
        .arvalid   (w_arvalid),
        .araddr    (w_araddr)
    );

    // On reset, every AR the crossbar has taken (including one handshaking right now)
    // will still produce a beat; those are counted so they can be swallowed.
    // A reset held for two or more cycles settles the discard count to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= 2'd0;
            r_inflight <= 2'd0;
            r_discard  <= 3'(r_inflight) + 3'(w_ar_hs);
            r_data_ok  <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_cnt      <= r_cnt + 2'(w_accept) - 2'(r_data_ok);
            r_inflight <= r_inflight + 2'(w_ar_hs) - 2'(w_inflight_dec);
            if (w_r_hs && (r_discard != 3'd0)) begin
                r_discard <= r_discard - 3'd1;
            end
            r_data_ok  <= w_r_fwd;
            if (w_r_fwd) begin
                r_rdata <= bus.rdata;
            end
        end
    end

    assign bus.inst_sram_addr_ok = w_accept;
    assign bus.inst_sram_data_ok = r_data_ok;
    assign bus.inst_sram_rdata   = r_rdata;

    assign bus.arid    = AXI_ID;
    assign bus.araddr  = w_araddr;
    assign bus.arlen   = AXI_LEN_SINGLE;
    assign bus.arsize  = AXI_SIZE_WORD;
    assign bus.arburst = AXI_BURST_INCR;
    assign bus.arlock  = AXI_LOCK_NORMAL;
    assign bus.arcache = AXI_CACHE_NONE;
    assign bus.arprot  = AXI_PROT_NONE;
    assign bus.arvalid = w_arvalid;

    assign bus.rready  = ~reset;

    assign w_unused_r  = ^{bus.rid, bus.rresp, bus.rlast};

endmodule

`default_nettype wire

// File: tb/tb_inst_sram_axi_rd_bridge.sv
// ============================================================================
// Module   : tb_inst_sram_axi_rd_bridge
// Desc     : Scoreboard bench with a delayed in-order AXI read responder
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_sram_axi_rd_bridge;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    inst_sram_axi_rd_bridge_if bus();

    inst_sram_axi_rd_bridge #(
        .MAX_OUTSTANDING (2),
        .AXI_ID          (4'd0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          rdy;
    } ar_t;

    ar_t         ar_q[$];
    logic [31:0] exp_q[$];
    int cyc       = 0;
    int r_delay   = 1;
    int dok_count = 0;
    int dok_cyc   = 0;
    int acc_cyc   = 0;
    int n_cmp     = 0;
    int n_err     = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'hbfc00000: return 32'h3c1d8000;
            32'h1c000000: return 32'h11111111;
            32'h1c000004: return 32'h22222222;
            default:      return {a[15:0], ~a[15:0]};
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // In-order AXI responder: one beat per AR, no earlier than r_delay cycles after its handshake.
    always @(posedge clk) begin
        #1;
        if (ar_q.size() > 0 && cyc >= ar_q[0].rdy) begin
            bus.rvalid = 1'b1;
            bus.rdata  = mem_word(ar_q[0].addr);
        end else begin
            bus.rvalid = 1'b0;
            bus.rdata  = 32'h0;
        end
    end

    always @(negedge clk) begin
        ar_t e;
        if (bus.inst_sram_req && bus.inst_sram_addr_ok) begin
            exp_q.push_back(mem_word({bus.inst_sram_addr[31:2], 2'b00}));
            acc_cyc = cyc;
        end
        if (bus.rvalid && bus.rready) ar_q.pop_front();
        if (bus.arvalid && bus.arready) begin
            e.addr = bus.araddr;
            e.rdy  = cyc + r_delay;
            ar_q.push_back(e);
        end
        if (bus.inst_sram_data_ok) begin
            dok_count++;
            dok_cyc = cyc;
            check_value("dok_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check_value("rdata", bus.inst_sram_rdata, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [31:0] a);
        int waited = 0;
        bus.inst_sram_req  = 1'b1;
        bus.inst_sram_addr = a;
        #1;
        while (bus.inst_sram_addr_ok !== 1'b1 && waited < 40) begin
            tick();
            waited++;
            #1;
        end
        check_value("accept", bus.inst_sram_addr_ok, 1);
        tick();
        bus.inst_sram_req = 1'b0;
    endtask

    task automatic wait_dok();
        int start = dok_count;
        int n = 0;
        while (dok_count == start && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_value("dok_seen", dok_count - start, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || ar_q.size() != 0) && n < 60) begin
            tick();
            n++;
        end
        check_value("drain", exp_q.size(), 0);
    endtask

    initial begin
        int start;
        int n;
        bus.inst_sram_req  = 1'b0;
        bus.inst_sram_addr = 32'h0;
        bus.arready        = 1'b1;
        bus.rvalid         = 1'b0;
        bus.rdata          = 32'h0;
        bus.rid            = 4'd0;
        bus.rresp          = 2'd0;
        bus.rlast          = 1'b1;

        // Reset state, with a request asserted that must be refused.
        repeat (3) tick();
        bus.inst_sram_req  = 1'b1;
        bus.inst_sram_addr = 32'h1c000010;
        #1;
        check_value("rst_addr_ok", bus.inst_sram_addr_ok, 0);
        check_value("rst_arvalid", bus.arvalid, 0);
        check_value("rst_araddr", bus.araddr, 0);
        check_value("rst_data_ok", bus.inst_sram_data_ok, 0);
        check_value("rst_rdata", bus.inst_sram_rdata, 0);
        check_value("ar_const", 32'({bus.arid, bus.arlen, bus.arsize, bus.arburst,
                                     bus.arlock, bus.arcache, bus.arprot}),
                    32'({4'd0, 8'd0, 3'd2, 2'b01, 2'b00, 4'd0, 3'd0}));
        tick();
        bus.inst_sram_req = 1'b0;
        reset = 1'b0;
        tick();
        #1;
        check_value("rready_after_rst", bus.rready, 1);
        tick();

        // Single fetch, minimum latency.
        r_delay = 1;
        issue(32'hbfc00000);
        #1;
        check_value("t1_arvalid", bus.arvalid, 1);
        check_value("t1_araddr", bus.araddr, 32'hbfc00000);
        wait_dok();
        check_value("t1_latency", dok_cyc - acc_cyc, 3);
        tick();
        #1;
        check_value("t1_dok_one_cycle", bus.inst_sram_data_ok, 0);
        check_value("t1_rdata_hold", bus.inst_sram_rdata, 32'h3c1d8000);
        wait_drain();

        // AR stall: slot holds, second request refused until the handshake.
        tick();
        bus.arready = 1'b0;
        issue(32'h1c000100);
        bus.inst_sram_req  = 1'b1;
        bus.inst_sram_addr = 32'h1c000200;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_value("t2_arvalid_hold", bus.arvalid, 1);
            check_value("t2_araddr_hold", bus.araddr, 32'h1c000100);
            check_value("t2_addr_ok_blocked", bus.inst_sram_addr_ok, 0);
            tick();
        end
        bus.arready = 1'b1;
        #1;
        check_value("t2_addr_ok_at_hs", bus.inst_sram_addr_ok, 0);
        issue(32'h1c000200);
        wait_drain();

        // Two outstanding with slow R; a third waits for the first data_ok.
        tick();
        r_delay = 6;
        issue(32'h1c000000);
        issue(32'h1c000004);
        start = dok_count;
        issue(32'h1c000008);
        check_value("t3_third_after_first_dok", dok_count - start, 1);
        wait_drain();

        // Accept in the same cycle data_ok fires: count stays at one.
        tick();
        r_delay = 1;
        issue(32'h1c000300);
        tick();
        tick();
        bus.inst_sram_req  = 1'b1;
        bus.inst_sram_addr = 32'h1c000304;
        #1;
        check_value("t4_dok_now", bus.inst_sram_data_ok, 1);
        check_value("t4_addr_ok_now", bus.inst_sram_addr_ok, 1);
        issue(32'h1c000304);
        tick();
        bus.inst_sram_req  = 1'b1;
        bus.inst_sram_addr = 32'h1c000308;
        #1;
        check_value("t4_cnt_one_accept", bus.inst_sram_addr_ok, 1);
        issue(32'h1c000308);
        wait_drain();

        // Reset with two ARs in flight; a fresh request must get its own data.
        tick();
        r_delay = 8;
        issue(32'h1c000400);
        issue(32'h1c000404);
        tick();
        reset = 1'b1;
        exp_q.delete();
        start = dok_count;
        tick();
        reset = 1'b0;
        r_delay = 1;
        issue(32'h1c000500);
        n = 0;
        while (ar_q.size() > 0 && n < 40) begin
            #1;
            if (bus.rvalid) check_value("t5_rready_stale", bus.rready, 1);
            tick();
            n++;
        end
        tick();
        tick();
        check_value("t5_dok_count", dok_count - start, 1);
        wait_drain();

        // Unaligned request address is word-aligned on AR.
        tick();
        issue(32'h1c000606);
        #1;
        check_value("t6_araddr_aligned", bus.araddr, 32'h1c000604);
        wait_drain();

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
